// File: rtl/fir_pe_ctrl.sv
// fir_pe_ctrl: sequencer for an N_PE-stage systolic FIR array. It holds the coefficient
// register file, paces array issue with credit and gap control, and buffers results in a FIFO.
module fir_pe_ctrl #(
    parameter int N_PE       = 8,
    parameter int XW         = 4,
    parameter int YW         = 4,
    parameter int CW         = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 4,
    localparam int AW        = (N_PE > 1) ? $clog2(N_PE) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [CW-1:0]      cfg_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [XW-1:0]      s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [YW-1:0]      m_data,
    output logic               m_last,
    output logic               busy,
    output logic               err,
    output logic               pe_rdy,
    output logic [XW-1:0]      pe_xin,
    output logic [YW-1:0]      pe_yin,
    output logic [N_PE*CW-1:0] pe_cin,
    input  logic               pe_vld,
    input  logic [YW-1:0]      pe_yout
);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GW   = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam int DW   = $clog2(N_PE + 1);
    localparam logic [CNTW:0]   DEPTH_C = (CNTW+1)'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);
    localparam logic [PW-1:0]   PTR_MAX = PW'(FIFO_DEPTH - 1);
    localparam logic [GW-1:0]   GAP_MAX = GW'(ISSUE_GAP - 1);
    localparam logic [DW-1:0]   NPE_C   = DW'(N_PE);
    localparam logic [AW:0]     NPE_A   = (AW+1)'(N_PE);

    typedef enum logic [1:0] {S_CFG, S_RUN, S_DRAIN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_coef [N_PE];
    logic [YW:0]     r_mem [FIFO_DEPTH];
    logic [CNTW-1:0] r_out;
    logic [CNTW-1:0] r_cnt;
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [GW-1:0]   r_gap;
    logic [DW-1:0]   r_drainCnt;
    logic            r_peRdy;
    logic            r_err;
    logic [XW-1:0]   r_peXin;

    logic w_credit, w_gapOk, w_sReady, w_accept, w_drainDone, w_drainIssue;
    logic w_issue, w_ret, w_drop, w_pop, w_lastTag;

    function automatic logic [CW-1:0] coefDefault(input int idx);
        logic [CW-1:0] v;
        v = '0;
        if (N_PE == 8) begin
            case (idx)
                0, 7:    v = CW'(4);
                1, 6:    v = CW'(12);
                2, 5:    v = CW'(25);
                3, 4:    v = CW'(34);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Every issued sample must own a FIFO slot on return, since the array cannot stall.
    assign w_credit     = ({1'b0, r_out} + {1'b0, r_cnt}) < DEPTH_C;
    assign w_gapOk      = (r_gap == GAP_MAX);
    assign w_sReady     = (r_state == S_RUN) && w_credit && w_gapOk;
    assign w_accept     = s_valid && w_sReady;
    assign w_drainDone  = (r_drainCnt == NPE_C);
    assign w_drainIssue = (r_state == S_DRAIN) && !w_drainDone && w_credit && w_gapOk;
    assign w_issue      = w_accept || w_drainIssue;
    assign w_ret        = pe_vld && (r_out != '0);
    assign w_drop       = pe_vld && (r_out == '0);
    assign w_pop        = (r_cnt != '0) && m_ready;
    assign w_lastTag    = (r_state == S_DRAIN) && w_drainDone && (r_out == ONE_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_CFG;
            r_drainCnt <= '0;
        end else begin
            case (r_state)
                S_CFG: begin
                    if (run) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (!run) begin
                        r_state    <= S_DRAIN;
                        r_drainCnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (w_drainIssue) r_drainCnt <= r_drainCnt + 1'b1;
                    if (w_drainDone && r_out == '0) r_state <= S_CFG;
                end
                default: r_state <= S_CFG;
            endcase
        end
    end

    // The gap counter saturates at ISSUE_GAP-1, which also makes the first issue after reset legal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_peRdy <= 1'b0;
            r_peXin <= '0;
            r_gap   <= GAP_MAX;
            r_out   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_peRdy <= w_issue;
            if (w_issue) begin
                r_peXin <= w_accept ? s_data : '0;
                r_gap   <= '0;
            end else if (!w_gapOk) begin
                r_gap <= r_gap + 1'b1;
            end
            case ({w_issue, w_ret})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
            if (r_state != S_CFG && (cfg_we || w_drop)) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_ret) begin
                r_mem[r_wrPtr] <= {w_lastTag, pe_yout};
                r_wrPtr        <= (r_wrPtr == PTR_MAX) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) r_rdPtr <= (r_rdPtr == PTR_MAX) ? '0 : r_rdPtr + 1'b1;
            case ({w_ret, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_PE; i++) r_coef[i] <= coefDefault(i);
        end else if (cfg_we && r_state == S_CFG && {1'b0, cfg_addr} < NPE_A) begin
            r_coef[cfg_addr] <= cfg_data;
        end
    end

    for (genvar g = 0; g < N_PE; g++) begin : g_cin
        assign pe_cin[g*CW +: CW] = r_coef[g];
    end

    assign s_ready = w_sReady;
    assign m_valid = (r_cnt != '0);
    assign m_data  = r_mem[r_rdPtr][YW-1:0];
    assign m_last  = m_valid && r_mem[r_rdPtr][YW];
    assign busy    = (r_state != S_CFG);
    assign err     = r_err;
    assign pe_rdy  = r_peRdy;
    assign pe_xin  = r_peXin;
    assign pe_yin  = '0;

endmodule

// File: tb/tb_fir_pe_ctrl.sv
// tb_fir_pe_ctrl: directed bench for fir_pe_ctrl with a fixed-latency array model
// that returns ~Xin ten cycles after each pe_rdy.
module tb_fir_pe_ctrl;
    localparam int N_PE = 8;
    localparam int XW   = 4;
    localparam int YW   = 4;
    localparam int CW   = 6;

    logic              clk;
    logic              reset;
    logic              run;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [CW-1:0]     cfg_data;
    logic              s_valid;
    logic              s_ready;
    logic [XW-1:0]     s_data;
    logic              m_valid;
    logic              m_ready;
    logic [YW-1:0]     m_data;
    logic              m_last;
    logic              busy;
    logic              err;
    logic              pe_rdy;
    logic [XW-1:0]     pe_xin;
    logic [YW-1:0]     pe_yin;
    logic [N_PE*CW-1:0] pe_cin;
    logic              pe_vld;
    logic [YW-1:0]     pe_yout;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;
    int cycle   = 0;

    logic [CW-1:0] coefExp [N_PE];
    int            rdyCyc[$];
    logic [XW-1:0] rdyX[$];
    int            accCyc[$];
    logic [XW-1:0] accQ[$];
    logic [YW-1:0] resQ[$];
    logic          lastQ[$];

    logic [10:1]   dV;
    logic [XW-1:0] dX [1:10];
    logic          spur;

    fir_pe_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err), .pe_rdy(pe_rdy), .pe_xin(pe_xin), .pe_yin(pe_yin),
        .pe_cin(pe_cin), .pe_vld(pe_vld), .pe_yout(pe_yout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Array stand-in: a 10-deep delay line; spur forces an unsolicited result.
    always @(posedge clk) begin
        if (reset) dV <= '0;
        else       dV <= {dV[9:1], pe_rdy};
        dX[1] <= pe_xin;
        for (int i = 2; i <= 10; i++) dX[i] <= dX[i-1];
    end
    assign pe_vld  = dV[10] | spur;
    assign pe_yout = spur ? 4'h9 : ~dX[10];

    always @(negedge clk) begin
        if (pe_rdy) begin
            rdyCyc.push_back(cycle);
            rdyX.push_back(pe_xin);
        end
        if (s_valid && s_ready) begin
            accCyc.push_back(cycle);
            accQ.push_back(s_data);
        end
        if (m_valid && m_ready) begin
            resQ.push_back(m_data);
            lastQ.push_back(m_last);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Holds s_valid until n samples are accepted, stepping the data after each accept.
    task automatic applyStimulus(input int n);
        int   got   = 0;
        int   guard = 0;
        logic fire;
        s_valid = 1'b1;
        while (got < n && guard < 200) begin
            fire = s_ready;
            cyc();
            guard++;
            if (fire) begin
                got++;
                s_data = s_data + 4'd3;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic holdValid(input int nCycles);
        logic fire;
        s_valid = 1'b1;
        for (int i = 0; i < nCycles; i++) begin
            fire = s_ready;
            cyc();
            if (fire) s_data = s_data + 4'd3;
        end
        s_valid = 1'b0;
    endtask

    task automatic waitResults(input int n, input int budget);
        int guard = 0;
        while (resQ.size() < n && guard < budget) begin
            cyc();
            guard++;
        end
    endtask

    task automatic clearLogs();
        rdyCyc.delete(); rdyX.delete(); accCyc.delete();
        accQ.delete(); resQ.delete(); lastQ.delete();
    endtask

    task automatic setDefaultCoefs();
        coefExp = '{6'd4, 6'd12, 6'd25, 6'd34, 6'd34, 6'd25, 6'd12, 6'd4};
    endtask

    function automatic logic [N_PE*CW-1:0] packCoefs();
        logic [N_PE*CW-1:0] v;
        v = '0;
        for (int i = 0; i < N_PE; i++) v[i*CW +: CW] = coefExp[i];
        return v;
    endfunction

    initial begin
        logic [YW-1:0] expY;
        int            guard;
        int            zeros;
        int            lastCount;

        reset = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        s_valid = 1'b0; s_data = 4'd1; m_ready = 1'b0; spur = 1'b0;
        setDefaultCoefs();
        repeat (3) cyc();
        reset = 1'b0;

        checkOutput("rst_flags", {busy, s_ready, m_valid, m_last, pe_rdy, err}, 6'b0);
        checkOutput("rst_pe_xin", pe_xin, 0);
        checkOutput("rst_pe_yin", pe_yin, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_pe_cin", pe_cin, packCoefs());

        spur = 1'b1; cyc(); spur = 1'b0; cyc();
        checkOutput("cfg_vld_err", err, 0);
        checkOutput("cfg_vld_mvalid", m_valid, 0);

        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 6'd63; cyc(); cfg_we = 1'b0;
        coefExp[3] = 6'd63;
        checkOutput("cfg_coef3", pe_cin[23:18], 63);
        checkOutput("cfg_pe_cin", pe_cin, packCoefs());

        run = 1'b1; cyc();
        checkOutput("run_busy", busy, 1);
        checkOutput("run_s_ready", s_ready, 1);

        // Pacing: six samples, consumer always ready.
        clearLogs();
        m_ready = 1'b1;
        applyStimulus(6);
        waitResults(6, 100);
        checkOutput("pace_rdy_count", rdyCyc.size(), 6);
        checkOutput("pace_res_count", resQ.size(), 6);
        if (accCyc.size() > 0 && rdyCyc.size() > 0)
            checkOutput("pace_latency", rdyCyc[0] - accCyc[0], 1);
        for (int i = 1; i < rdyCyc.size(); i++)
            checkOutput($sformatf("pace_gap%0d", i), rdyCyc[i] - rdyCyc[i-1], 4);
        for (int i = 0; i < resQ.size() && i < accQ.size(); i++) begin
            expY = ~accQ[i];
            checkOutput($sformatf("pace_res%0d", i), resQ[i], expY);
        end
        checkOutput("pace_err", err, 0);

        // Credit backpressure followed by a pop coinciding with a result push.
        clearLogs();
        m_ready = 1'b0;
        holdValid(60);
        checkOutput("bp_accepted", accQ.size(), 4);
        checkOutput("bp_s_ready", s_ready, 0);
        checkOutput("bp_m_valid", m_valid, 1);
        checkOutput("bp_nothing_popped", resQ.size(), 0);
        m_ready = 1'b1; cyc(); m_ready = 1'b0;
        applyStimulus(1);
        guard = 0;
        while (!pe_vld && guard < 40) begin
            cyc();
            guard++;
        end
        checkOutput("sim_vld_seen", pe_vld, 1);
        m_ready = 1'b1; cyc(); m_ready = 1'b0;
        checkOutput("sim_m_valid", m_valid, 1);
        m_ready = 1'b1;
        waitResults(5, 100);
        checkOutput("sim_res_count", resQ.size(), 5);
        for (int i = 0; i < resQ.size() && i < accQ.size(); i++) begin
            expY = ~accQ[i];
            checkOutput($sformatf("sim_res%0d", i), resQ[i], expY);
        end
        checkOutput("sim_err", err, 0);

        // Drain: three samples, then end of stream.
        clearLogs();
        applyStimulus(3);
        run = 1'b0; cyc();
        checkOutput("drn_busy", busy, 1);
        checkOutput("drn_s_ready", s_ready, 0);
        guard = 0;
        while (busy && guard < 300) begin
            cyc();
            guard++;
        end
        repeat (5) cyc();
        checkOutput("drn_busy_fell", busy, 0);
        checkOutput("drn_rdy_count", rdyCyc.size(), 11);
        zeros = 0;
        for (int i = 3; i < rdyX.size(); i++) if (rdyX[i] == '0) zeros++;
        checkOutput("drn_zero_issues", zeros, 8);
        checkOutput("drn_res_count", resQ.size(), 11);
        for (int i = 0; i < resQ.size() && i < 11; i++) begin
            if (i < 3 && i < accQ.size()) expY = ~accQ[i];
            else                          expY = 4'hF;
            checkOutput($sformatf("drn_res%0d", i), resQ[i], expY);
        end
        lastCount = 0;
        foreach (lastQ[i]) if (lastQ[i]) lastCount++;
        checkOutput("drn_last_count", lastCount, 1);
        if (lastQ.size() > 10) checkOutput("drn_last_on_11th", lastQ[10], 1);
        checkOutput("drn_m_valid", m_valid, 0);
        checkOutput("drn_err", err, 0);

        // Error paths.
        run = 1'b1; cyc();
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 6'd5; cyc(); cfg_we = 1'b0;
        checkOutput("err_cfg_in_run", err, 1);
        checkOutput("err_coef_kept", pe_cin, packCoefs());
        reset = 1'b1; cyc(); reset = 1'b0;
        setDefaultCoefs();
        checkOutput("err_cleared", err, 0);
        checkOutput("err_rst_pe_cin", pe_cin, packCoefs());
        cyc();
        spur = 1'b1; cyc(); spur = 1'b0;
        checkOutput("err_spurious_run", err, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
